// File: rtl/signal_table_sequencer_if.sv
// signal_table_sequencer_if: host write port plus table RAM bus.
// Host side:  host_we, host_addr, host_data request a table write; host_ack confirms it.
// Table side: tbl_wr, tbl_addr and tbl_din drive the RAM; tbl_dout returns read data one cycle later.
// The slave modport is the sequencer's view; the master modport is the host/RAM view.
interface signal_table_sequencer_if #(
    parameter int data_width = 8,
    parameter int addr_width = 7
);
    logic                  host_we;
    logic [addr_width-1:0] host_addr;
    logic [data_width-1:0] host_data;
    logic                  host_ack;
    logic                  tbl_wr;
    logic [addr_width-1:0] tbl_addr;
    logic [data_width-1:0] tbl_din;
    logic [data_width-1:0] tbl_dout;
    modport slave (
        input  host_we, host_addr, host_data, tbl_dout,
        output host_ack, tbl_wr, tbl_addr, tbl_din
    );
    modport master (
        output host_we, host_addr, host_data, tbl_dout,
        input  host_ack, tbl_wr, tbl_addr, tbl_din
    );
endinterface

// File: rtl/signal_table_sequencer.sv
// signal_table_sequencer: plays a waveform table out of RAM at a programmable rate for a PWM stage.
// Ports: clk, rst_n (async active-low); bus (host write port + table RAM, slave modport);
//        start/stop level commands; last_addr/rate_div captured on start;
//        sample_out/sample_valid new duty sample; wrap end-of-waveform strobe; busy high while playing.
// Build option: SIGNAL_SEQ_MIRROR_EN selects triangle (up/down) addressing instead of sawtooth.
module signal_table_sequencer #(
    parameter int data_width = 8,
    parameter int addr_width = 7,
    parameter int div_width  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    signal_table_sequencer_if.slave bus,
    input  logic                  start,
    input  logic                  stop,
    input  logic [addr_width-1:0] last_addr,
    input  logic [div_width-1:0]  rate_div,
    output logic [data_width-1:0] sample_out,
    output logic                  sample_valid,
    output logic                  wrap,
    output logic                  busy
);
    typedef enum logic {IDLE, PLAY} state_t;
    state_t                state;
    logic [addr_width-1:0] ptr, lat_last, nxt_ptr;
    logic [div_width-1:0]  presc, lat_div;
    logic                  rd_issue, rd_pend, rd_wrap, nxt_wrap, take;
`ifdef SIGNAL_SEQ_MIRROR_EN
    logic                  dir, nxt_dir;
`endif
    // stop suppresses a read that would otherwise issue in the same cycle
    assign rd_issue = state == PLAY && !stop && presc == lat_div;
    // a read issued last cycle lands now unless stop discards it
    assign take = state == PLAY && rd_pend && !stop;
    // rst_n gates the combinational ack so reset forces it low immediately
    assign bus.host_ack = rst_n && state == IDLE && bus.host_we && !start;
    assign bus.tbl_wr   = bus.host_ack;
    assign bus.tbl_addr = rd_issue ? ptr : bus.host_addr;
    assign bus.tbl_din  = bus.host_data;
    assign busy         = state == PLAY;
`ifdef SIGNAL_SEQ_MIRROR_EN
    // dir=1 while descending; the index-0 read that ends a descent carries wrap
    always_comb begin
        nxt_dir  = dir;
        nxt_ptr  = ptr + 1'b1;
        nxt_wrap = 1'b0;
        if (dir) begin
            nxt_wrap = ptr == '0;
            nxt_ptr  = nxt_wrap ? addr_width'(1) : ptr - 1'b1;
            nxt_dir  = !nxt_wrap;
        end else if (ptr == lat_last) begin
            nxt_wrap = lat_last == '0;
            nxt_ptr  = nxt_wrap ? '0 : ptr - 1'b1;
            nxt_dir  = !nxt_wrap;
        end
    end
`else
    always_comb begin
        nxt_wrap = ptr == lat_last;
        nxt_ptr  = nxt_wrap ? '0 : ptr + 1'b1;
    end
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ptr          <= '0;
            presc        <= '0;
            lat_last     <= '0;
            lat_div      <= '0;
            rd_pend      <= 1'b0;
            rd_wrap      <= 1'b0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            wrap         <= 1'b0;
`ifdef SIGNAL_SEQ_MIRROR_EN
            dir          <= 1'b0;
`endif
        end else begin
            sample_valid <= take;
            wrap         <= take && rd_wrap;
            rd_pend      <= rd_issue;
            if (take) sample_out <= bus.tbl_dout;
            if (state == IDLE) begin
                if (start) begin
                    state    <= PLAY;
                    lat_last <= last_addr;
                    lat_div  <= rate_div;
                    ptr      <= '0;
                    presc    <= '0;
`ifdef SIGNAL_SEQ_MIRROR_EN
                    dir      <= 1'b0;
`endif
                end
            end else if (stop) begin
                state <= IDLE;
            end else begin
                presc <= presc == lat_div ? '0 : presc + 1'b1;
                if (rd_issue) begin
                    ptr     <= nxt_ptr;
                    rd_wrap <= nxt_wrap;
`ifdef SIGNAL_SEQ_MIRROR_EN
                    dir     <= nxt_dir;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_signal_table_sequencer.sv
// tb_signal_table_sequencer: vector-driven write checks and randomized playback against an arithmetic model.
module tb_signal_table_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, stop = 1'b0;
    logic [6:0]  last_addr = '0;
    logic [15:0] rate_div = '0;
    logic [7:0]  sample_out;
    logic        sample_valid, wrap, busy;
    logic [7:0]  ram [128];
    logic [7:0]  mdl [128];
    logic [7:0]  last_s = '0;
    int          tests = 0, fails = 0;

    typedef struct {
        logic       we;
        logic       stp;
        logic [6:0] addr;
        logic [7:0] data;
        logic       ack;
    } vec_t;
    vec_t vecs[13];

    signal_table_sequencer_if #(.data_width(8), .addr_width(7)) bus ();

    signal_table_sequencer #(.data_width(8), .addr_width(7), .div_width(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .start(start), .stop(stop),
        .last_addr(last_addr), .rate_div(rate_div), .sample_out(sample_out),
        .sample_valid(sample_valid), .wrap(wrap), .busy(busy)
    );

    always #5 clk = ~clk;

    // synchronous-read table RAM
    always @(posedge clk) begin
        if (bus.tbl_wr) ram[bus.tbl_addr] <= bus.tbl_din;
        bus.tbl_dout <= ram[bus.tbl_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // index of the k-th read of a waveform with end point l
    function automatic int exp_idx(input int k, input int l);
`ifdef SIGNAL_SEQ_MIRROR_EN
        int m;
        if (l == 0) return 0;
        m = k % (2 * l);
        return m <= l ? m : 2 * l - m;
`else
        return k % (l + 1);
`endif
    endfunction

    function automatic logic exp_wrap(input int k, input int l);
`ifdef SIGNAL_SEQ_MIRROR_EN
        return l == 0 || (k > 0 && k % (2 * l) == 0);
`else
        return exp_idx(k, l) == l;
`endif
    endfunction

    task automatic apply_vec(input vec_t v);
        bus.host_we = v.we; stop = v.stp; bus.host_addr = v.addr; bus.host_data = v.data;
        #1;
        chk("wr_ack", bus.host_ack, v.ack);
        chk("wr_tbl_wr", bus.tbl_wr, v.ack);
        chk("wr_tbl_addr", bus.tbl_addr, v.addr);
        chk("wr_tbl_din", bus.tbl_din, v.data);
        if (v.ack) mdl[v.addr] = v.data;
        @(negedge clk);
        chk("idle_busy", busy, 0);
    endtask

    // start a waveform, play ncyc cycles, then stop (or pull reset when rst_abort)
    task automatic run_play(input int l, input int d, input int ncyc, input bit rst_abort);
        int k;
        start = 1; stop = 0; last_addr = 7'(l); rate_div = 16'(d);
        bus.host_we = 1; bus.host_addr = 7'($urandom); bus.host_data = 8'($urandom);
        #1;
        chk("start_wins_ack", bus.host_ack, 0);
        chk("start_wins_wr", bus.tbl_wr, 0);
        @(negedge clk);
        for (int n = 0; n <= ncyc; n++) begin
            chk("play_busy", busy, 1);
            if (n - 1 >= d + 1 && (n - 1) % (d + 1) == 0) begin
                k = (n - 1) / (d + 1) - 1;
                chk("valid", sample_valid, 1);
                chk("sample", sample_out, mdl[exp_idx(k, l)]);
                chk("wrap", wrap, exp_wrap(k, l));
                last_s = mdl[exp_idx(k, l)];
            end else begin
                chk("no_valid", sample_valid, 0);
                chk("no_wrap", wrap, 0);
            end
            stop = n == ncyc && !rst_abort;
            start = stop ? 1'b0 : 1'($urandom);
            bus.host_we = stop ? 1'b0 : 1'($urandom);
            bus.host_addr = 7'($urandom); bus.host_data = 8'($urandom);
            #1;
            chk("play_ack", bus.host_ack, 0);
            chk("play_tbl_wr", bus.tbl_wr, 0);
            chk("play_din", bus.tbl_din, bus.host_data);
            if (!stop && (n + 1) % (d + 1) == 0)
                chk("rd_addr", bus.tbl_addr, exp_idx((n + 1) / (d + 1) - 1, l));
            else
                chk("host_addr_pass", bus.tbl_addr, bus.host_addr);
            @(negedge clk);
        end
        start = 0; stop = 0; bus.host_we = 0;
        if (!rst_abort) begin
            chk("stop_busy", busy, 0);
            chk("stop_valid", sample_valid, 0);
            chk("stop_wrap", wrap, 0);
            chk("stop_hold", sample_out, last_s);
        end else begin
            bus.host_we = 1; rst_n = 0;
            #1;
            chk("rst_sample", sample_out, 0);
            chk("rst_valid", sample_valid, 0);
            chk("rst_wrap", wrap, 0);
            chk("rst_busy", busy, 0);
            chk("rst_ack", bus.host_ack, 0);
            chk("rst_tbl_wr", bus.tbl_wr, 0);
            last_s = 0;
            @(negedge clk);
            bus.host_we = 0; rst_n = 1;
            repeat (3) begin
                @(negedge clk);
                chk("post_rst_busy", busy, 0);
                chk("post_rst_valid", sample_valid, 0);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        bus.host_we = 1; bus.host_addr = 7'd3; bus.host_data = 8'd5; start = 1;
        #2;
        chk("reset_sample", sample_out, 0);
        chk("reset_valid", sample_valid, 0);
        chk("reset_wrap", wrap, 0);
        chk("reset_busy", busy, 0);
        chk("reset_ack", bus.host_ack, 0);
        chk("reset_tbl_wr", bus.tbl_wr, 0);
        repeat (2) @(negedge clk);
        chk("reset_hold_busy", busy, 0);
        bus.host_we = 0; start = 0; rst_n = 1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) vecs[i] = '{1'b1, 1'b0, 7'(i), 8'(i), 1'b1};
        vecs[10] = '{1'b0, 1'b0, 7'd5, 8'hAA, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 7'd10, 8'h5A, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 7'd11, 8'h33, 1'b1};
        for (int i = 0; i < 13; i++) apply_vec(vecs[i]);
        for (int a = 12; a < 128; a++) apply_vec('{1'b1, 1'b0, 7'(a), 8'($urandom), 1'b1});
        bus.host_we = 0; stop = 0;

        run_play(3, 0, 12, 0);
        run_play(9, 4, 30, 0);
        run_play(9, 4, 5, 0);
        run_play(0, 0, 6, 0);
        run_play(1, 0, 8, 0);
        run_play(3, 0, 7, 1);
        for (int r = 0; r < 10; r++)
            run_play($urandom_range(0, 3) == 0 ? $urandom_range(0, 127) : $urandom_range(0, 6),
                     $urandom_range(0, 3), $urandom_range(8, 80), r == 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/signal_table_sequencer.md
SIGNAL_TABLE_SEQUENCER -- requirements
Module: signal_table_sequencer

Interface
REQ-001 Parameter data_width, default 8: sample and table word width in bits.
REQ-002 Parameter addr_width, default 7: table address width in bits.
REQ-003 Parameter div_width, default 16: width of the sample-rate prescaler.
REQ-004 Clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Rst_n  input  1  asynchronous, active-low reset.
REQ-006 start, stop  input  1 each  level-sampled playback commands.
REQ-007 last_addr  input  addr_width  final table index of the waveform; sampled on start.
REQ-008 rate_div  input  div_width  cycles between reads minus one; sampled on start.
REQ-009 host_we  input  1  host write request; host_addr (addr_width) and host_data (data_width) qualify it.
REQ-010 host_ack  output  1  write accepted this cycle.
REQ-011 tbl_wr  output  1, tbl_addr  output  addr_width, tbl_din  output  data_width  drive the table RAM.
REQ-012 tbl_dout  input  data_width  table read data, valid one cycle after tbl_addr with tbl_wr=0.
REQ-013 sample_out  output  data_width  current duty sample for the PWM stage; sample_valid  output  1  one-cycle strobe on update.
REQ-014 wrap  output  1  one-cycle strobe with the sample read from the waveform's end point; busy  output  1  high in PLAY.

Function
REQ-015 FSM SHALL have two states: IDLE, PLAY.
REQ-016 IDLE: host_we=1 and start=0 -> tbl_wr=1, tbl_addr=host_addr, tbl_din=host_data, host_ack=1, combinationally in the same cycle.
REQ-017 IDLE, start=1 -> PLAY next cycle; last_addr/rate_div latched; ptr=0; prescaler=0; start wins over a simultaneous host_we (host_ack=0).
REQ-018 PLAY: host_ack=0 and tbl_wr=0 always; the host must hold the request until return to IDLE.
REQ-019 PLAY: prescaler increments each cycle; when it equals latched rate_div it clears and a read of ptr is issued (tbl_addr=ptr).
REQ-020 One cycle after a read: sample_out<=tbl_dout, sample_valid=1; rate_div=0 gives one read per cycle, sample_valid continuously high.
REQ-021 Pointer advance on each read: ptr==latched last_addr -> ptr=0 and wrap asserted with that sample's sample_valid; else ptr+1.
REQ-022 last_addr=0 -> index 0 read repeatedly, wrap with every sample_valid.
REQ-023 stop=1 in PLAY -> IDLE next cycle; an in-flight read is discarded (no sample_valid); sample_out holds its last value; stop has priority over a same-cycle read issue.
REQ-024 start in PLAY and stop in IDLE SHALL be ignored.
REQ-025 tbl_addr SHALL equal host_addr whenever no read is issued; tbl_din=host_data always.

Reset
REQ-026 Rst_n=0 SHALL immediately force state IDLE, ptr=0, prescaler=0, sample_out=0, sample_valid=0, wrap=0, busy=0, host_ack=0, tbl_wr=0.
REQ-027 Reset mid-playback SHALL abort with no further strobes; after release, operation resumes only on a new start.

Configuration
REQ-028 Macro SIGNAL_SEQ_MIRROR_EN defined: ptr runs 0..L then L-1 down to 1 then 0 again (L = latched last_addr); wrap strobes on the sample read at index 0 after descent (period 2L reads); L=0 holds index 0 with wrap on every sample; L=1 alternates 0,1.
REQ-029 Macro undefined: sawtooth addressing per REQ-021; no direction register is synthesized.

Verification
REQ-030 Reset, IDLE writes addr 0..9 data 0..9 -> host_ack and tbl_wr high each write cycle, table holds values.
REQ-031 start with last_addr=3, rate_div=0 -> sample_out 0,1,2,3,0,1 on consecutive cycles, wrap with value 3.
REQ-032 rate_div=4, last_addr=9 -> sample_valid every 5 cycles, first strobe 6 cycles after start sampled.
REQ-033 stop in the cycle after a read issue -> no sample_valid, busy low next cycle, sample_out unchanged; host_we in PLAY -> host_ack=0 until IDLE.
REQ-034 Rst_n low mid-PLAY -> all outputs 0 asynchronously; start and host_we asserted together -> PLAY, no write.
REQ-035 SIGNAL_SEQ_MIRROR_EN, last_addr=3, rate_div=0 -> 0,1,2,3,2,1,0,1..., wrap at each return to 0.
